// File: rtl/score_matrix_mem.sv
// Score matrix storage for a dynamic-programming aligner: border init, 3-neighbour reads, cell writes.
// Optional macro SCORE_MATRIX_MEM_BYPASS_EN forwards same-cycle write data to colliding read outputs.
module score_matrix_mem #(
   parameter int ROWS = 128,
   parameter int COLS = 128,
   parameter int SW   = 9,
   parameter int GAP  = -1,
   parameter int AW   = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init_start,
   output logic          busy,
   output logic          init_done,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_i,
   input  logic [AW-1:0] rd_j,
   output logic          rd_valid,
   output logic [SW-1:0] diag,
   output logic [SW-1:0] up,
   output logic [SW-1:0] left,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_i,
   input  logic [AW-1:0] wr_j,
   input  logic [SW-1:0] wr_data,
   output logic          err
);

   localparam int DEPTH = (ROWS + 1) * (COLS + 1);
   localparam int MAW   = $clog2(DEPTH);
   localparam int LAST  = ROWS + COLS;
   localparam int CW    = $clog2(LAST + 1);

   typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   init_cnt;
   logic            init_last;
   logic [MAW-1:0]  init_addr;
   logic [SW-1:0]   init_data;
   int              init_k;

   int              ri;
   int              rj;
   int              wi;
   int              wj;
   logic            rd_ok;
   logic            rd_rej;
   logic            wr_ok;
   logic            wr_rej;
   logic [MAW-1:0]  rd_diag_addr;
   logic [MAW-1:0]  rd_up_addr;
   logic [MAW-1:0]  rd_left_addr;
   logic [MAW-1:0]  wr_addr;
   logic [SW-1:0]   diag_next;
   logic [SW-1:0]   up_next;
   logic [SW-1:0]   left_next;

   logic [SW-1:0]   mem [DEPTH];

   assign init_last = (init_cnt == CW'(LAST));
   assign busy      = (state == INIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (init_start) state_next = INIT;
         INIT:    if (init_last) state_next = READY;
         READY:   if (init_start) state_next = INIT;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         init_done <= (state == INIT) && init_last;
         if ((state == INIT) && !init_last) begin
            init_cnt <= init_cnt + 1'b1;
         end else begin
            init_cnt <= '0;
         end
      end
   end

   // Steps 0..COLS walk row 0; later steps walk column 0 from row 1 down.
   // Products are formed at 32-bit precision and truncated to SW bits.
   always_comb begin
      init_k    = int'(init_cnt);
      init_addr = '0;
      init_data = '0;
      if (init_k <= COLS) begin
         init_addr = MAW'(init_k);
         init_data = SW'(init_k * GAP);
      end else begin
         init_addr = MAW'((init_k - COLS) * (COLS + 1));
         init_data = SW'((init_k - COLS) * GAP);
      end
   end

   always_comb begin
      ri           = int'(rd_i);
      rj           = int'(rd_j);
      wi           = int'(wr_i);
      wj           = int'(wr_j);
      rd_ok        = rd_req && (state == READY) &&
                     (ri >= 1) && (ri <= ROWS) && (rj >= 1) && (rj <= COLS);
      rd_rej       = rd_req && !rd_ok;
      wr_ok        = wr_en && (state == READY) &&
                     (wi >= 1) && (wi <= ROWS) && (wj >= 1) && (wj <= COLS);
      wr_rej       = wr_en && !wr_ok;
      rd_diag_addr = MAW'((ri - 1) * (COLS + 1) + (rj - 1));
      rd_up_addr   = MAW'((ri - 1) * (COLS + 1) + rj);
      rd_left_addr = MAW'(ri * (COLS + 1) + (rj - 1));
      wr_addr      = MAW'(wi * (COLS + 1) + wj);
   end

   // Without forwarding, a colliding read naturally sees the pre-write contents.
   always_comb begin
      diag_next = mem[rd_diag_addr];
      up_next   = mem[rd_up_addr];
      left_next = mem[rd_left_addr];
`ifdef SCORE_MATRIX_MEM_BYPASS_EN
      if (wr_ok && (wr_addr == rd_diag_addr)) diag_next = wr_data;
      if (wr_ok && (wr_addr == rd_up_addr))   up_next   = wr_data;
      if (wr_ok && (wr_addr == rd_left_addr)) left_next = wr_data;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         diag     <= '0;
         up       <= '0;
         left     <= '0;
      end else begin
         rd_valid <= rd_ok;
         err      <= rd_rej || wr_rej;
         if (rd_ok) begin
            diag <= diag_next;
            up   <= up_next;
            left <= left_next;
         end
      end
   end

   // Storage is deliberately not reset; INIT owns the port while busy.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[init_addr] <= init_data;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_score_matrix_mem.sv
// Directed self-checking bench for score_matrix_mem (main instance 4x4/GAP=-2, plus a 4-bit truncation instance).
module tb_score_matrix_mem;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SW   = 9;
   localparam int GAP  = -2;
   localparam int AW   = 3;
   localparam int TSW  = 4;
   localparam int TGAP = -3;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_start;
   logic          busy;
   logic          init_done;
   logic          rd_req;
   logic [AW-1:0] rd_i;
   logic [AW-1:0] rd_j;
   logic          rd_valid;
   logic [SW-1:0] diag;
   logic [SW-1:0] up;
   logic [SW-1:0] left;
   logic          wr_en;
   logic [AW-1:0] wr_i;
   logic [AW-1:0] wr_j;
   logic [SW-1:0] wr_data;
   logic          err;

   logic           t_init_start;
   logic           t_busy;
   logic           t_init_done;
   logic           t_rd_req;
   logic [AW-1:0]  t_rd_i;
   logic [AW-1:0]  t_rd_j;
   logic           t_rd_valid;
   logic [TSW-1:0] t_diag;
   logic [TSW-1:0] t_up;
   logic [TSW-1:0] t_left;
   logic           t_err;

   int checks   = 0;
   int failures = 0;
   int n;

   always #5 clk = ~clk;

   score_matrix_mem #(.ROWS(ROWS), .COLS(COLS), .SW(SW), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .init_start(init_start), .busy(busy), .init_done(init_done),
      .rd_req(rd_req), .rd_i(rd_i), .rd_j(rd_j), .rd_valid(rd_valid),
      .diag(diag), .up(up), .left(left),
      .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data), .err(err)
   );

   score_matrix_mem #(.ROWS(ROWS), .COLS(COLS), .SW(TSW), .GAP(TGAP)) dut_t (
      .clk(clk), .rst(rst), .init_start(t_init_start), .busy(t_busy), .init_done(t_init_done),
      .rd_req(t_rd_req), .rd_i(t_rd_i), .rd_j(t_rd_j), .rd_valid(t_rd_valid),
      .diag(t_diag), .up(t_up), .left(t_left),
      .wr_en(1'b0), .wr_i('0), .wr_j('0), .wr_data('0), .err(t_err)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int i, input int j);
      rd_req = 1'b1;
      rd_i   = AW'(i);
      rd_j   = AW'(j);
      tick();
      rd_req = 1'b0;
   endtask

   task automatic do_write(input int i, input int j, input logic [SW-1:0] d);
      wr_en   = 1'b1;
      wr_i    = AW'(i);
      wr_j    = AW'(j);
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic check_read(input string tag, input logic [SW-1:0] d, input logic [SW-1:0] u,
                             input logic [SW-1:0] l);
      check_output({tag, "_valid"}, rd_valid, 1);
      check_output({tag, "_err"}, err, 0);
      check_output({tag, "_diag"}, diag, d);
      check_output({tag, "_up"}, up, u);
      check_output({tag, "_left"}, left, l);
   endtask

   task automatic check_reject(input string tag);
      check_output({tag, "_err"}, err, 1);
      check_output({tag, "_valid"}, rd_valid, 0);
   endtask

   // Pulses init_start, then counts busy cycles; optionally reads or re-requests init mid-way.
   task automatic run_init(input int rd_at, input int start_at, output int cycles);
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 50) begin
         if (cycles == rd_at) begin
            rd_req = 1'b1;
            rd_i   = 3'd1;
            rd_j   = 3'd1;
         end
         if (cycles == start_at) init_start = 1'b1;
         tick();
         rd_req     = 1'b0;
         init_start = 1'b0;
         if (cycles == rd_at) check_reject("init_rd");
         cycles++;
      end
   endtask

   initial begin
      rst = 1'b1; init_start = 1'b0; rd_req = 1'b0; rd_i = '0; rd_j = '0;
      wr_en = 1'b0; wr_i = '0; wr_j = '0; wr_data = '0;
      t_init_start = 1'b0; t_rd_req = 1'b0; t_rd_i = '0; t_rd_j = '0;
      tick();
      tick();
      check_output("rst_busy", busy, 0);
      check_output("rst_done", init_done, 0);
      check_output("rst_valid", rd_valid, 0);
      check_output("rst_err", err, 0);
      check_output("rst_diag", diag, 0);
      rst = 1'b0;
      tick();

      $display("[TB] accesses before init");
      do_read(1, 1);
      check_reject("idle_rd");
      tick();
      check_output("err_one_cycle", err, 0);
      do_write(1, 1, 9'd5);
      check_output("idle_wr_err", err, 1);

      $display("[TB] border init");
      run_init(3, -1, n);
      check_output("init_busy_cycles", n, 9);
      check_output("init_done_pulse", init_done, 1);
      check_output("init_busy_low", busy, 0);
      tick();
      check_output("init_done_clear", init_done, 0);

      do_read(1, 1);
      check_read("rd11", 9'h000, 9'h1FE, 9'h1FE);
      tick();
      check_output("hold_valid", rd_valid, 0);
      check_output("hold_up", up, 9'h1FE);

      $display("[TB] writes and reads");
      do_write(1, 1, 9'd5);
      check_output("wr_err", err, 0);
      do_write(1, 2, 9'd6);
      do_write(2, 1, 9'h1FD);
      do_read(2, 2);
      check_read("rd22", 9'd5, 9'd6, 9'h1FD);

      rd_req = 1'b1; rd_i = 3'd1; rd_j = 3'd2;
      tick();
      check_read("b2b_a", 9'h1FE, 9'h1FC, 9'd5);
      rd_i = 3'd2; rd_j = 3'd1;
      tick();
      rd_req = 1'b0;
      check_read("b2b_b", 9'h1FE, 9'd5, 9'h1FC);

      $display("[TB] range checks");
      do_read(0, 3);
      check_reject("rd03");
      check_output("rd03_hold", up, 9'd5);
      do_read(5, 1);
      check_reject("rd51");
      do_write(5, 1, 9'd9);
      check_output("wr51_err", err, 1);
      do_write(1, 5, 9'h0AA);
      check_output("wr15_err", err, 1);
      do_write(0, 1, 9'h0BB);
      check_output("wr01_err", err, 1);
      do_read(2, 1);
      check_read("alias20", 9'h1FE, 9'd5, 9'h1FC);
      do_read(1, 1);
      check_read("border01", 9'h000, 9'h1FE, 9'h1FE);

      $display("[TB] read/write collisions");
      rd_req = 1'b1; rd_i = 3'd2; rd_j = 3'd2;
      wr_en = 1'b1; wr_i = 3'd1; wr_j = 3'd1; wr_data = 9'd7;
      tick();
      rd_req = 1'b0; wr_en = 1'b0;
`ifdef SCORE_MATRIX_MEM_BYPASS_EN
      check_read("coll_diag", 9'd7, 9'd6, 9'h1FD);
`else
      check_read("coll_diag", 9'd5, 9'd6, 9'h1FD);
`endif
      do_read(2, 2);
      check_read("after_coll", 9'd7, 9'd6, 9'h1FD);
      rd_req = 1'b1; rd_i = 3'd2; rd_j = 3'd2;
      wr_en = 1'b1; wr_i = 3'd2; wr_j = 3'd1; wr_data = 9'd1;
      tick();
      rd_req = 1'b0; wr_en = 1'b0;
`ifdef SCORE_MATRIX_MEM_BYPASS_EN
      check_read("coll_left", 9'd7, 9'd6, 9'd1);
`else
      check_read("coll_left", 9'd7, 9'd6, 9'h1FD);
`endif

      $display("[TB] re-init ignoring init_start while busy");
      run_init(-1, 4, n);
      check_output("reinit_cycles", n, 9);
      check_output("reinit_done", init_done, 1);
      do_read(1, 2);
      check_read("reinit_rd12", 9'h1FE, 9'h1FC, 9'd7);

      $display("[TB] reset during init");
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      tick();
      tick();
      check_output("midinit_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_output("abort_busy", busy, 0);
      check_output("abort_done", init_done, 0);
      check_output("abort_valid", rd_valid, 0);
      check_output("abort_err", err, 0);
      check_output("abort_diag", diag, 0);
      check_output("abort_up", up, 0);
      check_output("abort_left", left, 0);
      tick();
      rst = 1'b0;
      tick();
      check_output("abort_stays_idle", busy, 0);
      do_read(1, 1);
      check_reject("abort_rd");
      run_init(-1, -1, n);
      check_output("abort_reinit_cycles", n, 9);
      do_read(1, 1);
      check_read("abort_rd11", 9'h000, 9'h1FE, 9'h1FE);

      $display("[TB] truncation instance");
      t_init_start = 1'b1;
      tick();
      t_init_start = 1'b0;
      n = 0;
      while (t_init_done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check_output("t_init_cycles", n, 9);
      t_rd_req = 1'b1; t_rd_i = 3'd1; t_rd_j = 3'd4;
      tick();
      t_rd_req = 1'b0;
      check_output("t_rd14_valid", t_rd_valid, 1);
      check_output("t_rd14_up", t_up, 4'd4);
      check_output("t_rd14_diag", t_diag, 4'd7);
      t_rd_req = 1'b1; t_rd_i = 3'd1; t_rd_j = 3'd1;
      tick();
      t_rd_req = 1'b0;
      check_output("t_rd11_diag", t_diag, 4'd0);
      check_output("t_rd11_up", t_up, 4'hD);
      check_output("t_rd11_left", t_left, 4'hD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
